dp_ram_fifo: RTL and testbench
==============================

DP_RAM_FIFO -- requirements
Module: dp_ram_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning stored word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, meaning RAM address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 The block SHALL have port clock  input  1  single clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port clear  input  1  synchronous flush, active-high.
REQ-006 The block SHALL have port in_data  input  DATA_WIDTH  write-side word.
REQ-007 The block SHALL have port in_valid  input  1  write-side word present.
REQ-008 The block SHALL have port in_ready  output  1  write side can accept.
REQ-009 The block SHALL have port out_data  output  DATA_WIDTH  read-side word.
REQ-010 The block SHALL have port out_valid  output  1  read-side word present.
REQ-011 The block SHALL have port out_ready  input  1  consumer accepts.
REQ-012 The block SHALL have port fill_level  output  ADDR_WIDTH+1  words accepted and not yet popped.

Function
REQ-013 Push SHALL occur when in_valid and in_ready are high at a rising edge; pop SHALL occur when out_valid and out_ready are high.
REQ-014 The RAM SHALL be written only on port A, at write pointer wr_ptr; port B SHALL be read-only (we_b tied low), at read pointer rd_ptr.
REQ-015 wr_ptr and rd_ptr SHALL be ADDR_WIDTH bits, increment by one per write/read issue, and wrap from DEPTH-1 to 0.
REQ-016 in_ready SHALL equal (fill_level < DEPTH), derived from registered state only; no push is accepted when full, even with a simultaneous pop.
REQ-017 fill_level SHALL increment on push only, decrement on pop only, and hold on simultaneous push and pop.
REQ-018 The output stage SHALL be a 2-entry skid buffer plus a 1-bit read_pending flag covering the RAM's 1-cycle read latency.
REQ-019 A RAM read SHALL be issued when unread RAM words exist and (skid occupancy + read_pending) < 2, or when it is < 3 and a pop occurs that cycle.
REQ-020 A read SHALL never target the address written in the same cycle; words become readable the cycle after their write.
REQ-021 First-word latency SHALL be 2 cycles from push to out_valid on an empty FIFO.
REQ-022 Sustained throughput SHALL be one word per cycle with in_valid and out_ready held high.
REQ-023 out_data/out_valid SHALL be driven from skid entry 0 and SHALL hold stable while out_valid is high and out_ready is low.
REQ-024 Ordering SHALL be strict FIFO across pointer wrap-around.
REQ-025 clear SHALL zero pointers, fill_level, skid occupancy and read_pending; it SHALL discard any in-flight read and override a same-cycle push or pop.

Reset
REQ-026 On reset low, wr_ptr, rd_ptr, fill_level, read_pending and skid occupancy SHALL be 0; out_valid SHALL be 0; out_data SHALL be 0.
REQ-027 in_ready SHALL be low while reset is asserted and high from the first edge after release.
REQ-028 Reset asserted mid-transfer SHALL discard all stored words; RAM contents are not cleared and are never exposed as valid.

Structure
REQ-029 No shared package SHALL be needed; DEPTH SHALL be a local parameter.
REQ-030 Storage SHALL be one instance of the existing true_dp_ram sub-module, with the same DATA_WIDTH and ADDR_WIDTH.
REQ-031 The block SHALL contain no other sub-modules.

Verification (ADDR_WIDTH=2, DATA_WIDTH=16)
REQ-032 Push 0xA1 into an empty FIFO with out_ready=1 -> out_valid rises 2 cycles later with out_data=0xA1; fill_level goes 1 then 0.
REQ-033 Push 0x10..0x13 with out_ready=0 -> in_ready falls after the 4th push and fill_level=4; a 5th in_valid is not accepted; draining yields 0x10..0x13 in order.
REQ-034 Stream 0x00..0x0B continuously with in_valid=out_ready=1 -> 12 words out in order with pointer wrap; one word per cycle after 2-cycle latency.
REQ-035 Toggle out_ready pseudo-randomly during 20 words -> no loss or duplication; out_data is stable during stalls.
REQ-036 clear with fill_level=3 and a read in flight -> next cycle fill_level=0 and out_valid=0; a subsequent push of 0x55 emerges as the first word.
REQ-037 Assert reset mid-stream with fill_level=2 -> out_valid=0 and fill_level=0 immediately; after release, in_ready=1 and the FIFO behaves as empty.

Source files
------------

// File: rtl/true_dp_ram.sv
// Dual-port RAM, two independent read/write ports sharing one clock.
// Latency: registered read, data valid the cycle after the address is presented.
// Backpressure: none, every port accepts an access every cycle.
module true_dp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] din_a,
    output logic [DATA_WIDTH-1:0] dout_a,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] din_b,
    output logic [DATA_WIDTH-1:0] dout_b
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Both ports write and read-first; contents are never reset.
    always_ff @(posedge clock) begin
        if (we_a) begin
            mem[addr_a] <= din_a;
        end
        if (we_b) begin
            mem[addr_b] <= din_b;
        end
        dout_a <= mem[addr_a];
        dout_b <= mem[addr_b];
    end

endmodule

// File: rtl/dp_ram_fifo.sv
// FIFO on a dual-port RAM with a 2-entry skid buffer absorbing the RAM read latency.
// Latency: 2 cycles from push to out_valid on an empty FIFO; 1 word/cycle sustained.
// Backpressure: in_ready drops at DEPTH words; out_data holds while out_ready is low.
module dp_ram_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   fill_level
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_LVL = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   fill_cnt;
    logic [ADDR_WIDTH:0]   ram_cnt;      // written words not yet read out of the RAM
    logic                  read_pending; // RAM read issued last cycle, data on ram_rd_dat now
    logic                  rdy_en;       // keeps in_ready low until the first edge after reset
    logic [1:0]            skid_cnt;
    logic [DATA_WIDTH-1:0] skid0;
    logic [DATA_WIDTH-1:0] skid1;

    logic [DATA_WIDTH-1:0] ram_rd_dat;
    logic [DATA_WIDTH-1:0] unused_dout_a;
    logic [DATA_WIDTH-1:0] zero_dat;

    logic                  push;
    logic                  pop;
    logic [1:0]            occ;
    logic                  rd_issue;
    logic [1:0]            cnt_after_pop;
    logic [1:0]            skid_cnt_n;
    logic [DATA_WIDTH-1:0] skid0_n;
    logic [DATA_WIDTH-1:0] skid1_n;

    assign zero_dat   = '0;
    assign in_ready   = rdy_en && (fill_cnt < FULL_LVL);
    assign out_valid  = (skid_cnt != 2'd0);
    assign out_data   = skid0;
    assign fill_level = fill_cnt;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Skid slots plus the in-flight read; never exceeds 2 because of the issue rule.
    assign occ = skid_cnt + {1'b0, read_pending};

    // ram_cnt only counts completed writes, so a read never hits this cycle's write address.
    assign rd_issue = (ram_cnt != '0) &&
                      ((occ < 2'd2) || ((occ < 2'd3) && pop));

    // Next skid contents: shift on pop, then land returning RAM data in the first free slot.
    always_comb begin
        skid0_n       = skid0;
        skid1_n       = skid1;
        cnt_after_pop = skid_cnt - {1'b0, pop};
        if (pop) begin
            skid0_n = skid1;
        end
        if (read_pending) begin
            if (cnt_after_pop == 2'd0) begin
                skid0_n = ram_rd_dat;
            end else begin
                skid1_n = ram_rd_dat;
            end
        end
        skid_cnt_n = cnt_after_pop + {1'b0, read_pending};
    end

    // Input acceptance opens on the first edge after reset release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    // Pointers and counters; clear discards everything including a read in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill_cnt     <= '0;
            ram_cnt      <= '0;
            read_pending <= 1'b0;
        end else if (clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill_cnt     <= '0;
            ram_cnt      <= '0;
            read_pending <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fill_cnt <= fill_cnt + 1'b1;
                2'b01:   fill_cnt <= fill_cnt - 1'b1;
                default: fill_cnt <= fill_cnt;
            endcase
            ram_cnt      <= ram_cnt + {{ADDR_WIDTH{1'b0}}, push}
                                    - {{ADDR_WIDTH{1'b0}}, rd_issue};
            read_pending <= rd_issue;
        end
    end

    // Output skid buffer; entry 0 drives the consumer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            skid_cnt <= 2'd0;
            skid0    <= '0;
            skid1    <= '0;
        end else if (clear) begin
            skid_cnt <= 2'd0;
            skid0    <= '0;
            skid1    <= '0;
        end else begin
            skid_cnt <= skid_cnt_n;
            skid0    <= skid0_n;
            skid1    <= skid1_n;
        end
    end

    true_dp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clock  (clock),
        .we_a   (push),
        .addr_a (wr_ptr),
        .din_a  (in_data),
        .dout_a (unused_dout_a),
        .we_b   (1'b0),
        .addr_b (rd_ptr),
        .din_b  (zero_dat),
        .dout_b (ram_rd_dat)
    );

endmodule

// File: tb/tb_dp_ram_fifo.sv
// Scoreboard bench for dp_ram_fifo with a 4-deep, 16-bit configuration.
// Latency: expected words are queued at acceptance and compared at each pop.
// Backpressure: out_ready is driven low, toggled and high across the directed vectors.
module tb_dp_ram_fifo;

    localparam int DW = 16;
    localparam int AW = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          clear = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW:0]   fill_level;

    int passes = 0;
    int total  = 0;
    int pops   = 0;
    logic [DW-1:0] exp_q [$];

    logic          hold_prev = 1'b0;
    logic [DW-1:0] data_prev = '0;

    dp_ram_fifo #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fill_level (fill_level)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: stall stability, then pop/compare, then record accepted pushes.
    always @(negedge clock) begin
        if (hold_prev && reset) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'(data_prev));
        end
        hold_prev = reset && !clear && out_valid && !out_ready;
        data_prev = out_data;
        if (!reset || clear) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL pop_unexpected: got 0x%0h required no word", out_data);
                end else begin
                    check("pop_order", 32'(out_data), 32'(exp_q.pop_front()));
                    pops++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops_base;
        int pushed;
        logic acc;
        logic [31:0] pat;
        pat = 32'b1011_0010_1110_0101_1001_1100_0111_0100;

        // Reset state
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_fill", 32'(fill_level), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        check("rel_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        check("rel_in_ready_high", 32'(in_ready), 32'd1);

        // Single word latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h00A1;
        tick();
        in_valid = 1'b0;
        check("lat_fill1", 32'(fill_level), 32'd1);
        check("lat_valid0", 32'(out_valid), 32'd0);
        tick();
        check("lat_valid1", 32'(out_valid), 32'd0);
        tick();
        check("lat_valid2", 32'(out_valid), 32'd1);
        check("lat_data", 32'(out_data), 32'h00A1);
        check("lat_fill2", 32'(fill_level), 32'd1);
        tick();
        check("lat_fill_end", 32'(fill_level), 32'd0);
        check("lat_valid_end", 32'(out_valid), 32'd0);

        // Fill to full with consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(16'h0010 + i);
            tick();
        end
        in_data = 16'h0014;
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_fill", 32'(fill_level), 32'd4);
        tick();
        tick();
        check("full_fill_hold", 32'(fill_level), 32'd4);
        check("full_out_data", 32'(out_data), 32'h0010);
        in_valid  = 1'b0;
        pops_base = pops;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && fill_level != 0; k++) begin
            tick();
        end
        check("full_drain_fill", 32'(fill_level), 32'd0);
        check("full_drain_pops", 32'(pops - pops_base), 32'd4);

        // Continuous stream across pointer wrap
        pops_base = pops;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i);
            check("stream_in_ready", 32'(in_ready), 32'd1);
            tick();
            if (i >= 2) begin
                check("stream_valid", 32'(out_valid), 32'd1);
                check("stream_data", 32'(out_data), 32'(i - 2));
            end
        end
        in_valid = 1'b0;
        tick();
        check("stream_tail12", 32'(out_data), 32'd10);
        tick();
        check("stream_tail13", 32'(out_data), 32'd11);
        tick();
        check("stream_done", 32'(out_valid), 32'd0);
        check("stream_pops", 32'(pops - pops_base), 32'd12);

        // Random-looking out_ready during 20 words
        pops_base = pops;
        pushed    = 0;
        for (int k = 0; k < 200 && pushed < 20; k++) begin
            in_valid  = 1'b1;
            in_data   = 16'(16'h0100 + pushed);
            out_ready = pat[k % 32];
            acc       = in_ready;
            tick();
            if (acc) begin
                pushed++;
            end
        end
        in_valid = 1'b0;
        for (int k = 0; k < 200 && fill_level != 0; k++) begin
            out_ready = pat[(k + 7) % 32];
            tick();
        end
        check("toggle_pushed", 32'(pushed), 32'd20);
        check("toggle_pops", 32'(pops - pops_base), 32'd20);
        check("toggle_fill", 32'(fill_level), 32'd0);

        // Clear with three words stored and a read in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(16'h0021 + i);
            tick();
        end
        check("clr_pre_fill", 32'(fill_level), 32'd3);
        check("clr_pre_valid", 32'(out_valid), 32'd1);
        in_valid  = 1'b1;
        in_data   = 16'h0099;
        out_ready = 1'b1;
        clear     = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_fill", 32'(fill_level), 32'd0);
        check("clr_valid", 32'(out_valid), 32'd0);
        tick();
        tick();
        check("clr_valid_later", 32'(out_valid), 32'd0);
        check("clr_fill_later", 32'(fill_level), 32'd0);
        in_valid = 1'b1;
        in_data  = 16'h0055;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("clr_next_valid", 32'(out_valid), 32'd1);
        check("clr_next_data", 32'(out_data), 32'h0055);
        tick();
        check("clr_next_fill", 32'(fill_level), 32'd0);

        // Reset mid-stream with two words stored
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(16'h0031 + i);
            tick();
        end
        in_valid = 1'b0;
        check("mid_pre_fill", 32'(fill_level), 32'd2);
        tick();
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_fill", 32'(fill_level), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        tick();
        reset = 1'b1;
        check("mid_rel_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        check("mid_rel_in_ready", 32'(in_ready), 32'd1);
        check("mid_rel_valid", 32'(out_valid), 32'd0);
        check("mid_rel_fill", 32'(fill_level), 32'd0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h0077;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("mid_next_valid", 32'(out_valid), 32'd1);
        check("mid_next_data", 32'(out_data), 32'h0077);
        tick();
        check("mid_next_fill", 32'(fill_level), 32'd0);

        tick();
        tick();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
